// File: rtl/wb_master_arbiter_pkg.sv
// Shared types and constants for the Wishbone N-master arbiter.
package wb_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/wb_master_arbiter_pick.sv
// Combinational picker: round-robin starting after ptr, or fixed lowest-index-first.
module wb_arb_pick
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int PTR_WIDTH   = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [PTR_WIDTH-1:0]   ptr,
   input  logic                   mode,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic                   valid
);

   localparam int unsigned NM = NUM_MASTERS;

   logic [PTR_WIDTH-1:0] idx;

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NM; k++) begin
         if (mode == 1'(PRIO_FIXED))
            idx = PTR_WIDTH'(k);
         else
            idx = PTR_WIDTH'((32'(ptr) + k + 32'd1) % NM);
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// N-master to 1-slave classic Wishbone arbiter with registered one-hot grant,
// round-robin or fixed priority, and bounded-burst preemption on ack edges.
module wb_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS   = 2,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int PRIORITY_MODE = 0,
   parameter int MAX_BURST     = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_MASTERS-1:0]                m_wb_cyc_i,
   input  logic [NUM_MASTERS-1:0]                m_wb_stb_i,
   input  logic [NUM_MASTERS-1:0]                m_wb_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_wb_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wb_dat_i,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_wb_sel_i,
   output logic [NUM_MASTERS-1:0]                m_wb_ack_o,
   output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
   output logic                                  s_wb_cyc_o,
   output logic                                  s_wb_stb_o,
   output logic                                  s_wb_we_o,
   output logic [ADDR_WIDTH-1:0]                 s_wb_adr_o,
   output logic [DATA_WIDTH-1:0]                 s_wb_dat_o,
   output logic [DATA_WIDTH/8-1:0]               s_wb_sel_o,
   input  logic                                  s_wb_ack_i,
   input  logic [DATA_WIDTH-1:0]                 s_wb_dat_i,
   output logic [NUM_MASTERS-1:0]                grant_o
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int PW = $clog2(NUM_MASTERS);
   localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] BURST_LAST = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;

   arb_state_t             state, state_nx;
   logic [NUM_MASTERS-1:0] grant, grant_nx, pick_req, pick_gnt, others;
   logic [PW-1:0]          rr_ptr, rr_ptr_nx, pick_idx;
   logic [BW-1:0]          burst_cnt, burst_nx;
   logic                   pick_valid, rearb, acked;

   wb_arb_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .PTR_WIDTH   (PW)
   ) u_pick (
      .req   (pick_req),
      .ptr   (rr_ptr),
      .mode  (PRIORITY_MODE == PRIO_FIXED),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++)
         if (pick_gnt[i]) pick_idx = PW'(i);
   end

   assign acked  = s_wb_ack_i && |(grant & m_wb_stb_i);
   assign others = m_wb_cyc_i & ~grant;

   // With MAX_BURST==0 the counter never leaves zero, so preemption is disabled.
   always_comb begin
      state_nx  = state;
      grant_nx  = grant;
      rr_ptr_nx = rr_ptr;
      burst_nx  = burst_cnt;
      pick_req  = m_wb_cyc_i;
      rearb     = 1'b0;
      unique case (state)
         ARB_IDLE: rearb = |m_wb_cyc_i;
         ARB_GRANT: begin
            pick_req = others;
            if (!(|(m_wb_cyc_i & grant)))
               rearb = 1'b1;
            else if (MAX_BURST > 0 && acked && burst_cnt == BURST_LAST && |others)
               rearb = 1'b1;
            else if (acked && burst_cnt != BURST_LAST)
               burst_nx = burst_cnt + 1'b1;
         end
      endcase
      if (rearb) begin
         burst_nx = '0;
         if (pick_valid) begin
            state_nx  = ARB_GRANT;
            grant_nx  = pick_gnt;
            rr_ptr_nx = pick_idx;
         end else begin
            state_nx = ARB_IDLE;
            grant_nx = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ARB_IDLE;
         grant     <= '0;
         rr_ptr    <= PW'(NUM_MASTERS - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_nx;
         grant     <= grant_nx;
         rr_ptr    <= rr_ptr_nx;
         burst_cnt <= burst_nx;
      end
   end

   always_comb begin
      s_wb_cyc_o = 1'b0;
      s_wb_stb_o = 1'b0;
      s_wb_we_o  = 1'b0;
      s_wb_adr_o = '0;
      s_wb_dat_o = '0;
      s_wb_sel_o = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (state == ARB_GRANT && grant[i]) begin
            s_wb_cyc_o = m_wb_cyc_i[i];
            s_wb_stb_o = m_wb_stb_i[i];
            s_wb_we_o  = m_wb_we_i[i];
            s_wb_adr_o = m_wb_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            s_wb_dat_o = m_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            s_wb_sel_o = m_wb_sel_i[i*SW +: SW];
         end
      end
   end

   assign m_wb_ack_o = grant & m_wb_stb_i & {NUM_MASTERS{s_wb_ack_i}};
   assign m_wb_dat_o = s_wb_dat_i;
   assign grant_o    = grant;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench: 2-master RR arbiter with a registered-ack slave and scoreboard,
// plus a 3-master fixed-priority instance driven cycle by cycle.
module tb_wb_master_arbiter;

   localparam logic [31:0] KEY = 32'h5EAD_BEEF;

   typedef struct {
      int unsigned m;
      logic [31:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;

   // ---------------- DUT A: N=2, round-robin, MAX_BURST=4 ----------------
   logic [1:0]  a_cyc, a_stb, a_we, a_ack, a_grant;
   logic [63:0] a_adr_bus, a_dat_bus;
   logic [7:0]  a_sel_bus;
   logic [31:0] a_mdat, a_sadr, a_sdat, a_sdat_i;
   logic [3:0]  a_ssel;
   logic        a_scyc, a_sstb, a_swe, a_sack;

   wb_master_arbiter #(
      .NUM_MASTERS   (2),
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .PRIORITY_MODE (0),
      .MAX_BURST     (4)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .m_wb_cyc_i (a_cyc),
      .m_wb_stb_i (a_stb),
      .m_wb_we_i  (a_we),
      .m_wb_adr_i (a_adr_bus),
      .m_wb_dat_i (a_dat_bus),
      .m_wb_sel_i (a_sel_bus),
      .m_wb_ack_o (a_ack),
      .m_wb_dat_o (a_mdat),
      .s_wb_cyc_o (a_scyc),
      .s_wb_stb_o (a_sstb),
      .s_wb_we_o  (a_swe),
      .s_wb_adr_o (a_sadr),
      .s_wb_dat_o (a_sdat),
      .s_wb_sel_o (a_ssel),
      .s_wb_ack_i (a_sack),
      .s_wb_dat_i (a_sdat_i),
      .grant_o    (a_grant)
   );

   // Registered-ack slave: acks lat+1 edges after seeing stb, returns adr ^ KEY.
   int unsigned lat;
   int unsigned wcnt;
   always @(posedge clk) begin
      if (!rst_n) begin
         a_sack   <= 1'b0;
         a_sdat_i <= '0;
         wcnt     <= 0;
      end else if (a_scyc && a_sstb && !a_sack) begin
         if (wcnt >= lat) begin
            a_sack   <= 1'b1;
            a_sdat_i <= a_sadr ^ KEY;
            wcnt     <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         a_sack <= 1'b0;
         wcnt   <= 0;
      end
   end

   // ---------------- DUT B: N=3, fixed priority, unlimited burst ----------------
   logic [2:0]  b_cyc, b_ack, b_grant;
   logic [95:0] b_adr_bus;
   logic [31:0] b_mdat, b_sadr, b_sdat;
   logic [3:0]  b_ssel;
   logic        b_scyc, b_sstb, b_swe, b_sack;

   assign b_adr_bus = {32'h0000_C002, 32'h0000_C001, 32'h0000_C000};

   wb_master_arbiter #(
      .NUM_MASTERS   (3),
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .PRIORITY_MODE (1),
      .MAX_BURST     (0)
   ) dut_fx (
      .clk        (clk),
      .reset      (rst_n),
      .m_wb_cyc_i (b_cyc),
      .m_wb_stb_i (b_cyc),
      .m_wb_we_i  (3'b000),
      .m_wb_adr_i (b_adr_bus),
      .m_wb_dat_i (96'd0),
      .m_wb_sel_i (12'hFFF),
      .m_wb_ack_o (b_ack),
      .m_wb_dat_o (b_mdat),
      .s_wb_cyc_o (b_scyc),
      .s_wb_stb_o (b_sstb),
      .s_wb_we_o  (b_swe),
      .s_wb_adr_o (b_sadr),
      .s_wb_dat_o (b_sdat),
      .s_wb_sel_o (b_ssel),
      .s_wb_ack_i (b_sack),
      .s_wb_dat_i (32'h1234_5678),
      .grant_o    (b_grant)
   );

   // ---------------- master models and scoreboard for DUT A ----------------
   int          rem  [2];
   logic [31:0] madr [2];
   logic [31:0] mdat [2];
   logic [3:0]  msel [2];
   logic [1:0]  mwe;
   exp_t        sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input int unsigned m, input logic [31:0] d);
      exp_t e;
      e.m = m;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic drive_a();
      for (int i = 0; i < 2; i++) begin
         a_cyc[i] = rem[i] > 0;
         a_stb[i] = rem[i] > 0;
         a_we[i]  = mwe[i];
         a_adr_bus[i*32 +: 32] = madr[i];
         a_dat_bus[i*32 +: 32] = mdat[i];
         a_sel_bus[i*4 +: 4]   = msel[i];
      end
   endtask

   task automatic tick();
      logic [1:0] pc, pg;
      logic       pr;
      exp_t       e;
      @(negedge clk);
      pc = a_cyc;
      pg = a_grant;
      pr = rst_n;
      chk("a_grant_onehot0", 32'($onehot0(a_grant)), 32'd1);
      if (a_ack != 2'b00) chk("a_ack_onehot", 32'($onehot(a_ack)), 32'd1);
      for (int i = 0; i < 2; i++) begin
         if (a_ack[i]) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_ack", 32'(i), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("ack_master", 32'(i), e.m);
               chk("ack_data", a_mdat, e.d);
               chk("s_adr_mux", a_sadr, madr[i]);
               chk("s_we_mux", 32'(a_swe), 32'(mwe[i]));
               chk("s_dat_mux", a_sdat, mdat[i]);
               chk("s_sel_mux", 32'(a_ssel), 32'(msel[i]));
            end
            rem[i]--;
            madr[i] += 32'd4;
         end
      end
      @(posedge clk);
      #1;
      if (pr && pg != 2'b00 && (pc & pg) == 2'b00 && (pc & ~pg) != 2'b00)
         chk("no_idle_handoff", 32'(a_grant), 32'(pc & ~pg));
      drive_a();
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (sb.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic clear_masters();
      for (int i = 0; i < 2; i++) begin
         rem[i]  = 0;
         madr[i] = '0;
         mdat[i] = '0;
         msel[i] = 4'hF;
      end
      mwe = 2'b00;
      sb.delete();
      drive_a();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      b_cyc = 3'b000;
      clear_masters();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      lat    = 0;
      b_cyc  = 3'b000;
      b_sack = 1'b0;
      clear_masters();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 32'(a_grant), 32'd0);
      chk("rst_s_cyc", 32'(a_scyc), 32'd0);
      chk("rst_s_stb", 32'(a_sstb), 32'd0);
      chk("rst_s_we", 32'(a_swe), 32'd0);
      chk("rst_s_adr", a_sadr, 32'd0);
      chk("rst_s_dat", a_sdat, 32'd0);
      chk("rst_s_sel", 32'(a_ssel), 32'd0);
      chk("rst_m_ack", 32'(a_ack), 32'd0);
      chk("rst_b_grant", 32'(b_grant), 32'd0);
      rst_n = 1'b1;

      // Fixed priority, three masters.
      b_cyc = 3'b010; tick();
      chk("t3_m1_grant", 32'(b_grant), 32'b010);
      chk("t3_m1_adr", b_sadr, 32'h0000_C001);
      b_cyc = 3'b011; tick();
      chk("t3_m1_holds", 32'(b_grant), 32'b010);
      b_cyc = 3'b001; tick();
      chk("t3_m0_on_release", 32'(b_grant), 32'b001);
      chk("t3_m0_adr", b_sadr, 32'h0000_C000);
      b_cyc = 3'b100; tick();
      chk("t3_m2_grant", 32'(b_grant), 32'b100);
      b_cyc = 3'b111; tick();
      chk("t3_m2_holds", 32'(b_grant), 32'b100);
      b_cyc = 3'b011; tick();
      chk("t3_order_m0", 32'(b_grant), 32'b001);
      b_cyc = 3'b110; tick();
      chk("t3_order_m1", 32'(b_grant), 32'b010);
      chk("t3_no_ack", 32'(b_ack), 32'd0);
      b_cyc = 3'b000; tick();
      chk("t3_idle", 32'(b_grant), 32'd0);

      // Single read, slave answers with DEADBEEF.
      lat     = 1;
      rem[0]  = 1;
      madr[0] = 32'h8000_0000;
      push(0, 32'hDEAD_BEEF);
      drive_a();
      tick();
      chk("t1_grant_latency", 32'(a_grant), 32'b01);
      chk("t1_s_cyc", 32'(a_scyc), 32'd1);
      drain("t1_drain", 20);
      tick();
      chk("t1_release", 32'(a_grant), 32'd0);

      // Simultaneous requests after reset; m1 writes.
      do_reset();
      lat     = 0;
      rem[0]  = 1;
      madr[0] = 32'h0000_0100;
      rem[1]  = 1;
      madr[1] = 32'h0000_0200;
      mwe[1]  = 1'b1;
      mdat[1] = 32'hCAFE_0001;
      msel[1] = 4'b0011;
      push(0, 32'h0000_0100 ^ KEY);
      push(1, 32'h0000_0200 ^ KEY);
      drive_a();
      tick();
      chk("t2_m0_first", 32'(a_grant), 32'b01);
      drain("t2_drain", 30);
      tick();
      chk("t2_idle", 32'(a_grant), 32'd0);

      // Burst preemption: m0 gets 4, m1 gets 2, m0 finishes 6.
      do_reset();
      lat     = 0;
      rem[0]  = 10;
      madr[0] = 32'h0000_1000;
      rem[1]  = 2;
      madr[1] = 32'h0000_2000;
      for (int k = 0; k < 4; k++) push(0, (32'h0000_1000 + 32'(4*k)) ^ KEY);
      for (int k = 0; k < 2; k++) push(1, (32'h0000_2000 + 32'(4*k)) ^ KEY);
      for (int k = 4; k < 10; k++) push(0, (32'h0000_1000 + 32'(4*k)) ^ KEY);
      drive_a();
      tick();
      chk("t4_m0_first", 32'(a_grant), 32'b01);
      drain("t4_drain", 100);
      tick();
      chk("t4_idle", 32'(a_grant), 32'd0);

      // Lone master past MAX_BURST: never preempted.
      rem[0]  = 10;
      madr[0] = 32'h0000_3000;
      for (int k = 0; k < 10; k++) push(0, (32'h0000_3000 + 32'(4*k)) ^ KEY);
      drive_a();
      tick();
      chk("t5_grant_start", 32'(a_grant), 32'b01);
      for (int n = 0; n < 60 && sb.size() > 0; n++) begin
         tick();
         chk("t5_grant_hold", 32'(a_grant), 32'b01);
      end
      chk("t5_drain", 32'(sb.size()), 32'd0);
      tick();
      chk("t5_idle", 32'(a_grant), 32'd0);

      // Reset mid-transfer, then RR pointer restarts at m0.
      lat     = 5;
      rem[0]  = 3;
      madr[0] = 32'h0000_4000;
      drive_a();
      tick();
      tick();
      tick();
      chk("t6_pre_grant", 32'(a_grant), 32'b01);
      chk("t6_pre_stb", 32'(a_sstb), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("t6_cyc_drop", 32'(a_scyc), 32'd0);
      chk("t6_grant_drop", 32'(a_grant), 32'd0);
      clear_masters();
      tick();
      rst_n   = 1'b1;
      lat     = 0;
      rem[0]  = 1;
      madr[0] = 32'h0000_5000;
      rem[1]  = 1;
      madr[1] = 32'h0000_6000;
      push(0, 32'h0000_5000 ^ KEY);
      push(1, 32'h0000_6000 ^ KEY);
      drive_a();
      tick();
      chk("t6_first_after_reset", 32'(a_grant), 32'b01);
      drain("t6_drain", 30);
      tick();
      chk("t6_idle", 32'(a_grant), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
